// File: rtl/ptc_status_pkg.sv
// Shared types and constants for the PTC status read-back block.
// Holds the readback word layout, counter widths and small helpers used by
// ptc_status_capture and its interface.
package ptc_status_pkg;

   localparam int unsigned IDX_W        = 5;
   localparam int unsigned CNT_W        = 16;
   localparam int unsigned TICK_DIV_DEF = 1000;
   localparam int unsigned TICK_W_DEF   = $clog2(TICK_DIV_DEF);

   // Word offsets of this block inside reg_ro_out
   localparam int unsigned RO_LIVE_OFS   = 0;
   localparam int unsigned RO_STICKY_OFS = 1;
   localparam int unsigned RO_STAT_OFS   = 2;

   // Layout of the status word at RO_STAT_OFS
   typedef struct packed {
      logic [9:0]       rsvd;
      logic             first_valid;
      logic [IDX_W-1:0] first_idx;
      logic [CNT_W-1:0] event_count;
   } stat_word_t;

   // Tick counter width for a given divider
   function automatic int unsigned tick_w(input int unsigned div);
      return (div < 2) ? 1 : $clog2(div);
   endfunction

   // Index of the lowest set bit (0 when none set)
   function automatic logic [IDX_W-1:0] lowest_idx(input logic [31:0] v);
      logic [IDX_W-1:0] idx;
      idx = '0;
      for (int i = 31; i >= 0; i--) begin
         if (v[i]) idx = IDX_W'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/ptc_status_capture_if.sv
// Register-side bundle of ptc_status_capture.
// master: register bridge (drives pins/mask/clear, reads status)
// slave : ptc_status_capture
interface ptc_status_capture_if #(
   parameter int unsigned N_IN = 32
);
   logic [N_IN-1:0]                    status_in;
   logic [N_IN-1:0]                    alert_mask;
   logic                               clear_req;
   logic [N_IN-1:0]                    status_live;
   logic [N_IN-1:0]                    status_sticky;
   logic [ptc_status_pkg::CNT_W-1:0]   event_count;
   logic                               first_valid;
   logic [ptc_status_pkg::IDX_W-1:0]   first_idx;
   logic                               alert_any;

   modport master (
      output status_in, alert_mask, clear_req,
      input  status_live, status_sticky, event_count, first_valid, first_idx, alert_any
   );

   modport slave (
      input  status_in, alert_mask, clear_req,
      output status_live, status_sticky, event_count, first_valid, first_idx, alert_any
   );
endinterface

// File: rtl/ptc_sync_debounce.sv
// One status bit: synchroniser, polarity normalisation, 3-sample tick
// debounce and the registered live level.
// Ports: clk_axi/aresetn clock and async active-low reset, pin_i raw pin,
//        tick_i shared sample strobe, live_o debounced asserted level.
module ptc_sync_debounce #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter bit          ACTIVE_LOW  = 1'b0
) (
   input  logic clk_axi,
   input  logic aresetn,
   input  logic pin_i,
   input  logic tick_i,
   output logic live_o
);
   localparam int unsigned HIST_W = 3;

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic [HIST_W-1:0]      hist_q, hist_d;
   logic                   live_q, live_d;
   logic                   s_c;

   // Live only moves once three consecutive tick samples agree
   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], pin_i};
      s_c    = sync_q[SYNC_STAGES-1] ^ ACTIVE_LOW;
      hist_d = hist_q;
      live_d = live_q;
      if (tick_i) begin
         hist_d = {hist_q[HIST_W-2:0], s_c};
         if ((hist_d == '0) || (hist_d == '1)) live_d = hist_d[0];
      end
   end

   always_ff @(posedge clk_axi or negedge aresetn) begin
      if (!aresetn) begin
         sync_q <= '0;
         hist_q <= '0;
         live_q <= 1'b0;
      end else begin
         sync_q <= sync_d;
         hist_q <= hist_d;
         live_q <= live_d;
      end
   end

   assign live_o = live_q;

endmodule

// File: rtl/ptc_status_capture.sv
// Read-back half of the PTC register bridge: debounces the board status
// pins and keeps sticky flags, a saturating event count and a first-fault index.
// Ports: clk_axi, aresetn (async, active low); bus (slave): status_in,
//        alert_mask, clear_req in; status_live, status_sticky, event_count,
//        first_valid, first_idx, alert_any out.
module ptc_status_capture
   import ptc_status_pkg::*;
#(
   parameter int unsigned N_IN        = 32,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned TICK_DIV    = 1000,
   parameter logic [31:0] ACTIVE_LOW  = 32'h0
) (
   input logic               clk_axi,
   input logic               aresetn,
   ptc_status_capture_if.slave bus
);
   localparam int unsigned TICK_W = tick_w(TICK_DIV);

   logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
   logic              tick_c;
   logic [N_IN-1:0]   live_vec;
   logic [N_IN-1:0]   live_prev_q;
   logic [N_IN-1:0]   sticky_q, sticky_d, base_sticky_c, newly_c;
   logic [CNT_W-1:0]  count_q, count_d, base_count_c;
   logic              first_valid_q, first_valid_d;
   logic [IDX_W-1:0]  first_idx_q, first_idx_d;
   logic              clear_req_q, clr_c;
   logic              alert_q, alert_d;

   for (genvar i = 0; i < N_IN; i++) begin : g_bit
      ptc_sync_debounce #(
         .SYNC_STAGES (SYNC_STAGES),
         .ACTIVE_LOW  (ACTIVE_LOW[i])
      ) u_db (
         .clk_axi (clk_axi),
         .aresetn (aresetn),
         .pin_i   (bus.status_in[i]),
         .tick_i  (tick_c),
         .live_o  (live_vec[i])
      );
   end

   // Clear is applied first so a set in the same cycle wins
   always_comb begin
      tick_c     = (tick_cnt_q == TICK_W'(TICK_DIV - 1));
      tick_cnt_d = tick_c ? '0 : tick_cnt_q + TICK_W'(1);

      clr_c         = bus.clear_req & ~clear_req_q;
      base_sticky_c = clr_c ? '0 : sticky_q;
      newly_c       = live_vec & ~live_prev_q & bus.alert_mask & ~base_sticky_c;
      sticky_d      = base_sticky_c | newly_c;

      base_count_c = clr_c ? '0 : count_q;
      count_d      = base_count_c;
      if ((|newly_c) && (base_count_c != '1)) count_d = base_count_c + CNT_W'(1);

      first_valid_d = clr_c ? 1'b0 : first_valid_q;
      first_idx_d   = clr_c ? '0   : first_idx_q;
      if (!first_valid_d && (|newly_c)) begin
         first_valid_d = 1'b1;
         first_idx_d   = lowest_idx(32'(newly_c));
      end

      alert_d = |(sticky_q & bus.alert_mask);
   end

   always_ff @(posedge clk_axi or negedge aresetn) begin
      if (!aresetn) begin
         tick_cnt_q    <= '0;
         live_prev_q   <= '0;
         sticky_q      <= '0;
         count_q       <= '0;
         first_valid_q <= 1'b0;
         first_idx_q   <= '0;
         clear_req_q   <= 1'b0;
         alert_q       <= 1'b0;
      end else begin
         tick_cnt_q    <= tick_cnt_d;
         live_prev_q   <= live_vec;
         sticky_q      <= sticky_d;
         count_q       <= count_d;
         first_valid_q <= first_valid_d;
         first_idx_q   <= first_idx_d;
         clear_req_q   <= bus.clear_req;
         alert_q       <= alert_d;
      end
   end

   assign bus.status_live   = live_vec;
   assign bus.status_sticky = sticky_q;
   assign bus.event_count   = count_q;
   assign bus.first_valid   = first_valid_q;
   assign bus.first_idx     = first_idx_q;
   assign bus.alert_any     = alert_q;

endmodule
